// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: requester IDs, port B address width and the
// read tag carried through the BRAM latency (also reused by the MMIO decoder).
package mem_bus_pkg;

  localparam int PORTB_ADDR_W = 15;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/bram_portb_arbiter_if.sv
// Requester-side and BRAM-side signals of the shared port B.
// slave: the arbiter's view; master: the requesters and BRAM around it.
interface bram_portb_arbiter_if #(
  parameter int ADDR_W = mem_bus_pkg::PORTB_ADDR_W
);
  logic              req0, req1;
  logic [3:0]        we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              lock1;
  logic              gnt0, gnt1, stall0;
  logic              rvalid0, rvalid1;
  logic [31:0]       rdata;
  logic              enaB;
  logic [3:0]        weB;
  logic [ADDR_W-1:0] addrB;
  logic [31:0]       dinB;
  logic [31:0]       doutB;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, doutB,
    output gnt0, gnt1, stall0, rvalid0, rvalid1, rdata, enaB, weB, addrB, dinB
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, doutB,
    input  gnt0, gnt1, stall0, rvalid0, rvalid1, rdata, enaB, weB, addrB, dinB
  );
endinterface

// File: rtl/rd_tag_pipe.sv
// Shift register of read tags matching the BRAM read latency.
module rd_tag_pipe
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  // Advance tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_portb_arbiter.sv
// Round-robin arbiter for BRAM port B between the CPU data path (0) and the
// loader/DMA engine (1), with a time-limited loader lock and read routing.
//
//   state    | meaning
//   UNLOCKED | round-robin between both requesters
//   LOCKED   | only requester 1 may be granted; CPU waits, lock_cnt counts
module bram_portb_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = PORTB_ADDR_W,
  parameter int READ_LATENCY = 1,
  parameter int MAX_LOCK     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  bram_portb_arbiter_if.slave  bus
);

  localparam int               CNT_W   = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam bit               LOCK_EN = (MAX_LOCK > 0);

  lock_state_t       state_q;
  logic [CNT_W-1:0]  lock_cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_q;
  logic              force0_q;
  logic              gnt0, gnt1;
  logic [3:0]        we_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [31:0]       din_mux;
  rd_tag_t           tag_in, tag_out;

  assign cnt_inc = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);

  // Grant decision: lock first, then the post-release CPU slot, then round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (state_q == LOCKED) begin
        gnt1 = bus.req1;
      end else if (force0_q && bus.req0) begin
        gnt0 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        gnt0 = (last_q == REQ_DMA);
        gnt1 = (last_q == REQ_CPU);
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  // Lock FSM, lock timer, forced-release slot and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      force0_q   <= 1'b0;
      last_q     <= REQ_DMA;
    end else begin
      force0_q <= 1'b0;
      if (gnt0 || gnt1) last_q <= gnt1;
      case (state_q)
        UNLOCKED: begin
          lock_cnt_q <= '0;
          if (LOCK_EN && gnt1 && bus.lock1) state_q <= LOCKED;
        end
        LOCKED: begin
          if (bus.req0) lock_cnt_q <= cnt_inc;
          if (!bus.lock1) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
          end else if (bus.req0 && (cnt_inc == CNT_MAX)) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
            force0_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= UNLOCKED;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  // Port B mux on the granted requester; idle port drives zeros.
  always_comb begin
    we_mux   = '0;
    addr_mux = '0;
    din_mux  = '0;
    if (gnt1) begin
      we_mux   = bus.we1;
      addr_mux = bus.addr1;
      din_mux  = bus.wdata1;
    end else if (gnt0) begin
      we_mux   = bus.we0;
      addr_mux = bus.addr0;
      din_mux  = bus.wdata0;
    end
  end

  assign tag_in.valid = (gnt0 || gnt1) && (we_mux == 4'h0);
  assign tag_in.id    = gnt1;

  rd_tag_pipe #(.DEPTH(READ_LATENCY)) u_rd_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.stall0  = !reset && bus.req0 && !gnt0;
  assign bus.enaB    = gnt0 || gnt1;
  assign bus.weB     = we_mux;
  assign bus.addrB   = addr_mux;
  assign bus.dinB    = din_mux;
  assign bus.rvalid0 = !reset && tag_out.valid && (tag_out.id == REQ_CPU);
  assign bus.rvalid1 = !reset && tag_out.valid && (tag_out.id == REQ_DMA);
  assign bus.rdata   = (!reset && tag_out.valid) ? bus.doutB : 32'h0;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Scoreboard bench: a rule-level reference predicts grants and port drive each
// cycle and queues expected read responses; a monitor pops them on rvalid.
module tb_bram_portb_arbiter;
  import mem_bus_pkg::*;

  localparam int AW = 15;
  localparam int RL = 1;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic reset;
  logic rst2;
  always #5 clk = ~clk;

  bram_portb_arbiter_if #(.ADDR_W(AW)) bus ();
  bram_portb_arbiter_if #(.ADDR_W(AW)) bus2 ();

  bram_portb_arbiter #(.ADDR_W(AW), .READ_LATENCY(RL), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  bram_portb_arbiter #(.ADDR_W(AW), .READ_LATENCY(2), .MAX_LOCK(0)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2.slave));

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] din);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = din[8*b +: 8];
    return w;
  endfunction

  // BRAM environment (read-first, 1-cycle latency)
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] dout_q = 32'h0;
  assign bus.doutB  = dout_q;
  assign bus2.doutB = 32'hC0DE0001;

  always @(posedge clk) begin
    if (bus.enaB) begin
      dout_q <= mem[bus.addrB];
      if (bus.weB != 4'h0) mem[bus.addrB] <= merge(mem[bus.addrB], bus.weB, bus.dinB);
    end
  end

  // Reference model
  typedef struct {
    bit          id;
    logic [31:0] data;
    longint      due;
  } exp_t;
  exp_t sbq[$];

  bit          m_last = 1'b1, m_locked = 1'b0, m_force = 1'b0;
  int          m_cnt = 0;
  bit          e0, e1;
  logic [3:0]  ewe;
  logic [14:0] eaddr;
  logic [31:0] edin;

  always @(negedge clk) begin
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset) begin
      if (m_locked)                      e1 = bus.req1;
      else if (m_force && bus.req0)      e0 = 1'b1;
      else if (bus.req0 && bus.req1)     begin e0 = m_last; e1 = !m_last; end
      else                               begin e0 = bus.req0; e1 = bus.req1; end
    end
    ewe   = e1 ? bus.we1    : e0 ? bus.we0    : 4'h0;
    eaddr = e1 ? bus.addr1  : e0 ? bus.addr0  : 15'h0;
    edin  = e1 ? bus.wdata1 : e0 ? bus.wdata0 : 32'h0;
    chk("gnt0", bus.gnt0, e0);
    chk("gnt1", bus.gnt1, e1);
    chk("stall0", bus.stall0, !reset && bus.req0 && !e0);
    chk("enaB", bus.enaB, e0 || e1);
    chk("weB", bus.weB, ewe);
    chk("addrB", bus.addrB, eaddr);
    chk("dinB", bus.dinB, edin);
    if (reset) begin
      m_last = 1'b1; m_locked = 1'b0; m_force = 1'b0; m_cnt = 0;
      sbq.delete();
    end else begin
      if (e0 || e1) begin
        if (ewe == 4'h0) sbq.push_back('{e1, ref_mem[eaddr], cyc + RL});
        else             ref_mem[eaddr] = merge(ref_mem[eaddr], ewe, edin);
        m_last = e1;
      end
      m_force = 1'b0;
      if (!m_locked) begin
        m_cnt = 0;
        if (e1 && bus.lock1 && ML > 0) m_locked = 1'b1;
      end else begin
        if (bus.req0 && m_cnt < ML) m_cnt++;
        if (!bus.lock1) begin
          m_locked = 1'b0; m_cnt = 0;
        end else if (bus.req0 && m_cnt == ML) begin
          m_locked = 1'b0; m_cnt = 0; m_force = 1'b1;
        end
      end
    end
  end

  // Response monitor
  exp_t got_e;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rvalid0 || bus.rvalid1) begin
        if (sbq.size() == 0) begin
          chk("rvalid_spurious", {bus.rvalid0, bus.rvalid1}, 2'b00);
        end else begin
          got_e = sbq.pop_front();
          chk("rvalid0", bus.rvalid0, !got_e.id);
          chk("rvalid1", bus.rvalid1, got_e.id);
          chk("rdata", bus.rdata, got_e.data);
          chk("rd_cycle", cyc, got_e.due);
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("rvalid_missing", bus.rvalid0 | bus.rvalid1, 1'b1);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_txn0();
    bus.req0   = ($urandom_range(0, 3) != 0);
    bus.we0    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    bus.addr0  = 15'($urandom_range(0, 15));
    bus.wdata0 = $urandom;
  endtask

  task automatic new_txn1();
    bus.req1   = ($urandom_range(0, 3) != 0);
    bus.we1    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    bus.addr1  = 15'($urandom_range(0, 15));
    bus.wdata1 = $urandom;
  endtask

  bit g0, g1, got;
  int stalls;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 32'h5A00_0000 ^ (i * 32'h0001_0103);
      ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0103);
    end
    reset = 1'b1;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.lock1 = 0;

    // request held across reset
    bus.req0 = 1'b1; bus.addr0 = 15'h010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt0", bus.gnt0, 1'b0);
      chk("rst_enaB", bus.enaB, 1'b0);
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt0", bus.gnt0, 1'b1);
    chk("post_rst_addrB", bus.addrB, 15'h010);
    tick();
    bus.req0 = 1'b0;

    // alternating conflict from reset state
    reset = 1'b1; tick(); reset = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 15'h010;
    bus.req1 = 1'b1; bus.we1 = 4'h0; bus.addr1 = 15'h020;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        chk("alt_gnt0", bus.gnt0, (i % 2) == 0);
        chk("alt_gnt1", bus.gnt1, (i % 2) == 1);
      end
      if (i > 0) begin
        chk("alt_rvalid0", bus.rvalid0, ((i - 1) % 2) == 0);
        chk("alt_rvalid1", bus.rvalid1, ((i - 1) % 2) == 1);
      end
      tick();
      if (i == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end

    // lock, timed forced release, re-lock
    reset = 1'b1; tick(); reset = 1'b0;
    bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.addr1 = 15'h020;
    @(negedge clk);
    chk("lock_first_gnt1", bus.gnt1, 1'b1);
    tick();
    bus.req0 = 1'b1; bus.addr0 = 15'h010;
    stalls = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt0) got = 1'b1;
      else if (bus.stall0) stalls++;
      tick();
    end
    chk("lock_release_gnt0", got, 1'b1);
    chk("lock_stall_cycles", stalls, 4);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("relock_gnt1", bus.gnt1, 1'b1);
    tick();
    bus.req0 = 1'b1;
    @(negedge clk);
    chk("relock_stall0", bus.stall0, 1'b1);
    tick();
    bus.lock1 = 1'b0; bus.req1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt0) got = 1'b1;
      tick();
    end
    chk("unlock_gnt0", got, 1'b1);
    bus.req0 = 1'b0;

    // byte write from requester 1, then CPU read-back
    bus.req1 = 1'b1; bus.we1 = 4'b0100; bus.addr1 = 15'h7FFF; bus.wdata1 = 32'h00AB_0000;
    @(negedge clk);
    chk("bw_gnt1", bus.gnt1, 1'b1);
    chk("bw_weB", bus.weB, 4'b0100);
    chk("bw_addrB", bus.addrB, 15'h7FFF);
    chk("bw_dinB", bus.dinB, 32'h00AB_0000);
    tick();
    bus.req1 = 1'b0; bus.we1 = 4'h0;
    bus.req0 = 1'b1; bus.we0 = 4'h0; bus.addr0 = 15'h7FFF;
    @(negedge clk);
    chk("bw_no_rvalid", bus.rvalid0 | bus.rvalid1, 1'b0);
    tick();
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("bw_rd_rvalid0", bus.rvalid0, 1'b1);
    chk("bw_rd_lane2", bus.rdata[23:16], 8'hAB);
    tick();

    // idle keeps history; last grant was CPU so DMA wins next conflict
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_enaB", bus.enaB, 1'b0);
      chk("idle_weB", bus.weB, 4'h0);
      tick();
    end
    bus.req0 = 1'b1; bus.addr0 = 15'h003;
    bus.req1 = 1'b1; bus.addr1 = 15'h004;
    @(negedge clk);
    chk("idle_conflict_gnt1", bus.gnt1, 1'b1);
    chk("idle_conflict_gnt0", bus.gnt0, 1'b0);
    tick();
    bus.req1 = 1'b0;
    @(negedge clk);
    tick();
    bus.req0 = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      g0 = bus.gnt0; g1 = bus.gnt1;
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if (g0 || !bus.req0) new_txn0();
      if (g1 || !bus.req1) new_txn1();
      if ($urandom_range(0, 7) == 0) bus.lock1 = ~bus.lock1;
    end
    reset = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // READ_LATENCY = 2, MAX_LOCK = 0 instance
  initial begin
    rst2 = 1'b1;
    bus2.req0 = 0; bus2.we0 = 0; bus2.addr0 = 0; bus2.wdata0 = 0;
    bus2.req1 = 0; bus2.we1 = 0; bus2.addr1 = 0; bus2.wdata1 = 0; bus2.lock1 = 0;
    for (int i = 0; i < 2; i++) tick();
    rst2 = 1'b0;
    bus2.req0 = 1'b1; bus2.addr0 = 15'h005;
    @(negedge clk); chk("rl2_gnt0", bus2.gnt0, 1'b1);
    tick(); bus2.req0 = 1'b0;
    @(negedge clk); chk("rl2_rvalid_early", bus2.rvalid0, 1'b0);
    tick();
    @(negedge clk);
    chk("rl2_rvalid", bus2.rvalid0, 1'b1);
    chk("rl2_rdata", bus2.rdata, 32'hC0DE0001);
    tick();
    @(negedge clk); chk("rl2_rvalid_once", bus2.rvalid0, 1'b0);
    tick();
    bus2.req0 = 1'b1; bus2.addr0 = 15'h006;
    @(negedge clk); chk("rl2_rst_gnt0", bus2.gnt0, 1'b1);
    tick(); rst2 = 1'b1;
    @(negedge clk); chk("rl2_rst_rvalid_n1", bus2.rvalid0, 1'b0);
    tick(); rst2 = 1'b0;
    @(negedge clk);
    chk("rl2_rst_rvalid_n2", bus2.rvalid0, 1'b0);
    chk("rl2_regrant", bus2.gnt0, 1'b1);
    tick(); bus2.req0 = 1'b0;
    @(negedge clk); chk("rl2_rst_rvalid_n3", bus2.rvalid0, 1'b0);
    tick();
    @(negedge clk); chk("rl2_regrant_rvalid", bus2.rvalid0, 1'b1);
    tick();
    bus2.req1 = 1'b1; bus2.lock1 = 1'b1; bus2.addr1 = 15'h007;
    @(negedge clk); chk("nolock_gnt1", bus2.gnt1, 1'b1);
    tick(); bus2.req0 = 1'b1;
    @(negedge clk); chk("nolock_gnt0", bus2.gnt0, 1'b1);
    tick();
    bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.lock1 = 1'b0;
  end

endmodule

// File: doc/bram_portb_arbiter.md
# bram_portb_arbiter

Shares the single CPU-side BRAM port B between two requesters: requester 0 is the CPU data-memory path (already byte-lane formatted, in front of the BRAM), requester 1 is the buffer loader/DMA engine. The block picks one request per cycle with round-robin priority. It supports a time-limited lock for loader bursts and tracks in-flight reads through the BRAM read latency, so each read response returns only to the requester that issued it. It also generates the CPU stall.

## Interface
Parameters:
- ADDR_W, 15, word address width of port B
- READ_LATENCY, 1, BRAM read latency in cycles; legal values are 1 or 2
- MAX_LOCK, 64, maximum number of consecutive cycles requester 1 may hold a lock while requester 0 is waiting

Ports:
- clk  in  1  single clock; all state is updated on its rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request valid for requester 0 / 1
- we0 / we1  in  4  byte-lane write enables; 0000 means a read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  32  write data, already lane-aligned
- lock1  in  1  requester 1 asks to keep the port for consecutive beats
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- stall0  out  1  req0 & ~gnt0; drives the CPU pipeline stall
- rvalid0 / rvalid1  out  1  read data valid for requester 0 / 1
- rdata  out  32  read data, broadcast to both requesters; qualified by the matching rvalid
- enaB  out  1  BRAM port B enable
- weB  out  4  BRAM byte write enables
- addrB  out  ADDR_W  BRAM word address
- dinB  out  32  BRAM write data
- doutB  in  32  BRAM read data

## Operation
- Handshake: a requester holds req, we, addr and wdata stable until it samples gnt high. A beat completes in the cycle where req & gnt are both high. A write needs no response.
- Port drive: enaB = gnt0 | gnt1. weB, addrB and dinB come from a mux on the granted requester. With no grant, all four are 0.
- Arbitration state is a `last` bit holding the ID of the last requester granted.
  - Only one requester asserts req: it is granted.
  - Both assert req: the requester ≠ `last` is granted.
  - `last` updates on every grant.
- Lock FSM states are UNLOCKED and LOCKED.
  - UNLOCKED → LOCKED when gnt1 & lock1.
  - In LOCKED, only requester 1 can be granted; req0 stalls.
  - LOCKED → UNLOCKED when lock1 falls, or when lock_cnt reaches MAX_LOCK while req0 is high.
- Forced release: in the cycle after a forced release, requester 0 is granted unconditionally if req0 is high. Requester 1 may re-lock afterwards.
- lock_cnt:
  - increments each LOCKED cycle in which req0 is high
  - saturates at MAX_LOCK
  - clears on entering UNLOCKED
  - is $clog2(MAX_LOCK+1) bits wide
- Read tracking: a READ_LATENCY-deep shift register holds {valid, id}. An entry is loaded when enaB & (weB == 0).
  - When the entry emerges, the block asserts rvalid[id] and sets rdata = doutB.
  - Write beats push valid = 0.

## Timing
- Grant latency is 0: req in cycle N gives gnt in cycle N when uncontended.
- A read granted in cycle N drives rvalid in cycle N + READ_LATENCY, for exactly one cycle.
- Back-to-back reads from alternating requesters are supported at 1 per cycle. Response order equals grant order.
- Read and write in consecutive cycles: no hazard handling. The BRAM is configured read-first, so a read in N+1 of a word written in N returns the new data.
- Reset values:
  - gnt0 = gnt1 = 0, stall0 = 0
  - rvalid0 = rvalid1 = 0, rdata = 0
  - enaB = 0, weB = 0, addrB = 0, dinB = 0
  - `last` = 1, so the CPU wins the first conflict
  - FSM = UNLOCKED, lock_cnt = 0
  - read shift register cleared
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset. A lock is released. A request held across reset is re-arbitrated in the first cycle after reset deasserts.
- Both requesters idle: the port is disabled and `last` holds its value.
- MAX_LOCK = 0 disables locking: lock1 is ignored.

## Structure
- Shared package `mem_bus_pkg` holds:
  - requester ID constants (REQ_CPU = 0, REQ_DMA = 1)
  - port B address width
  - the read-tag struct {valid, id}, for reuse by the MMIO decoder
- Sub-module `rd_tag_pipe` holds the parameterised READ_LATENCY shift register of tags, with synchronous clear on reset.
- The arbitration, lock FSM and port mux live in the top module. Expected size is about 200 lines total.

## Test plan
- Reset with req0 = 1 held across reset → gnt0 = 0, enaB = 0 during reset. gnt0 = 1 and addrB = addr0 in the first cycle after reset deasserts.
- req0 and req1 both held for 4 cycles (reads, addr0 = 0x010, addr1 = 0x020), starting from reset state → grants alternate 0,1,0,1. rvalid alternates 0,1,0,1 one cycle later (READ_LATENCY = 1). rdata matches the preloaded words.
- req1 with lock1 = 1 and req0 held, MAX_LOCK = 4 → 4 stalled cycles with stall0 = 1, then a forced release. gnt0 = 1 in the following cycle, then requester 1 re-locks.
- Byte write from requester 1: we1 = 0100, addr1 = 0x7FFF, wdata1 = 0x00AB0000 → weB = 0100, addrB = 0x7FFF, no rvalid. A subsequent read by requester 0 returns byte 0xAB in lane 2.
- READ_LATENCY = 2, reads granted in cycles N and N+1, reset asserted in N+1 → no rvalid in N+2 or N+3.
- Idle with both req = 0 for 3 cycles → enaB = 0, weB = 0, `last` unchanged. The next conflict grants the requester not granted last.
